blink_monitor: RTL

Receive-side checker for blinking-LED outputs: samples an LED drive signal, measures each ON and OFF interval in `clk` cycles, and reports whether every complete period matches the expected ON/OFF times. It sits beside an LED blinker, or on a looped-back LED pin, as a self-checking monitor for on-board and simulated blink-rate verification.

---
 rtl/blink_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/blink_monitor.sv
// blink_monitor: measures the ON and OFF intervals of a sampled LED drive
// signal in clk cycles and checks each complete ON+OFF period against
// the expected times, with a tolerance, an error count and a stuck-level
// timeout.
module blink_monitor #(
    parameter int CNT_W    = 16,
    parameter int ON_TIME  = 2,
    parameter int OFF_TIME = 2,
    parameter int TOL      = 0,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_in,
    output logic [CNT_W-1:0] on_len,
    output logic [CNT_W-1:0] off_len,
    output logic             period_valid,
    output logic             mismatch,
    output logic [7:0]       err_count,
    output logic             stuck,
    output logic             locked
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_REF  = CNT_W'(ON_TIME);
    localparam logic [CNT_W-1:0] OFF_REF = CNT_W'(OFF_TIME);
    localparam logic [CNT_W-1:0] TOL_REF = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_REF = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic             sync1, led_s, led_q;
    logic [2:0]       vld;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] on_nxt, off_nxt;
    logic             pv_nxt, mm_nxt, stuck_nxt, locked_nxt;
    logic [7:0]       err_nxt;
    logic             out_of_tol;

    // Larger minus smaller, so the difference never underflows.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Two-flop synchronizer, edge-detect delay flop, and a valid pipeline
    // that marks which stages hold real samples rather than reset zeros.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, as the hardware does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            led_s <= 1'b0;
            led_q <= 1'b0;
            vld   <= 3'b000;
        end else begin
            sync1 <= led_in;
            led_s <= sync1;
            led_q <= led_s;
            vld   <= {vld[1:0], 1'b1};
        end
    end

    // Edges count only once led_q holds a real sample, so the reset zeros
    // never fake a rise when the LED is already high at reset exit.
    assign rise = vld[2] &  led_s & ~led_q;
    assign fall = vld[2] & ~led_s &  led_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    // Next-state logic: SYNC waits for a clean rise, then HIGH/LOW alternate.
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC:    if (rise) state_nxt = HIGH;
            HIGH:    if (fall) state_nxt = LOW;
            LOW:     if (rise) state_nxt = HIGH;
            default: state_nxt = SYNC;
        endcase
    end

    // Period check against the stored ON length and the OFF length ending now.
    assign out_of_tol = (abs_diff(on_len, ON_REF) > TOL_REF) ||
                        (abs_diff(cnt, OFF_REF) > TOL_REF);

    // Saturating increment of the interval counter.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Output logic: next values of the counter and all registered outputs.
    always_comb begin
        cnt_nxt    = cnt;
        on_nxt     = on_len;
        off_nxt    = off_len;
        pv_nxt     = 1'b0;
        mm_nxt     = 1'b0;
        err_nxt    = err_count;
        stuck_nxt  = stuck;
        locked_nxt = locked;
        unique case (state)
            SYNC: begin
                if (rise) cnt_nxt = CNT_ONE;
            end
            HIGH: begin
                if (fall) begin
                    on_nxt    = cnt;
                    cnt_nxt   = CNT_ONE;
                    stuck_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TMO_REF) stuck_nxt = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    off_nxt    = cnt;
                    cnt_nxt    = CNT_ONE;
                    stuck_nxt  = 1'b0;
                    pv_nxt     = 1'b1;
                    locked_nxt = 1'b1;
                    if (out_of_tol) begin
                        mm_nxt = 1'b1;
                        if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TMO_REF) stuck_nxt = 1'b1;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            on_len       <= '0;
            off_len      <= '0;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            err_count    <= 8'd0;
            stuck        <= 1'b0;
            locked       <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            on_len       <= on_nxt;
            off_len      <= off_nxt;
            period_valid <= pv_nxt;
            mismatch     <= mm_nxt;
            err_count    <= err_nxt;
            stuck        <= stuck_nxt;
            locked       <= locked_nxt;
        end
    end

endmodule
